// File: rtl/bt_cmd_ctrl.sv
// Bluetooth byte-stream command parser driving the VGA display configuration.
// Optional inter-byte timeout is compiled in with `define BT_CMD_TIMEOUT_EN.
module bt_cmd_ctrl #(
   parameter int         TIMEOUT_CYCLES = 5_000_000,
   parameter logic [7:0] DEFAULT_COLOR  = 8'hFF,
   parameter logic [3:0] DEFAULT_SPEED  = 4'd1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       pausa,
   output logic [7:0] color,
   output logic [3:0] speed,
   output logic       cmd_ok,
   output logic       cmd_err,
   output logic       busy,
   output logic [1:0] state_dbg_o
);

   typedef enum logic [1:0] {IDLE, COL_HI, COL_LO, SPD} state_t;

   // rx handshake: a byte is consumed on every clk edge where rx_valid is
   // high; there is no back-pressure, so every strobed byte is processed.

   state_t     state_q;
   logic       pausa_q;
   logic [7:0] color_q;
   logic [3:0] speed_q;
   logic       cmd_ok_q;
   logic       cmd_err_q;
   logic       busy_q;
   logic [3:0] hi_q;

   logic       hex_ok;
   logic [3:0] hex_val;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("bt_cmd_ctrl: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef BT_CMD_TIMEOUT_EN
   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q;
`endif

   // Letters map to 10..15 via their low nibble (1..6) plus 9.
   always_comb begin
      hex_ok  = 1'b1;
      hex_val = 4'h0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         hex_val = rx_data[3:0];
      end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                   (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
         hex_val = rx_data[3:0] + 4'd9;
      end else begin
         hex_ok = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pausa_q   <= 1'b0;
         color_q   <= DEFAULT_COLOR;
         speed_q   <= DEFAULT_SPEED;
         cmd_ok_q  <= 1'b0;
         cmd_err_q <= 1'b0;
         busy_q    <= 1'b0;
         hi_q      <= 4'h0;
`ifdef BT_CMD_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         cmd_ok_q  <= 1'b0;
         cmd_err_q <= 1'b0;
         if (rx_valid) begin
`ifdef BT_CMD_TIMEOUT_EN
            cnt_q <= '0;
`endif
            case (state_q)
               IDLE: begin
                  case (rx_data)
                     8'h31: begin
                        pausa_q  <= ~pausa_q;
                        cmd_ok_q <= 1'b1;
                     end
                     8'h43: begin
                        state_q <= COL_HI;
                        busy_q  <= 1'b1;
                     end
                     8'h53: begin
                        state_q <= SPD;
                        busy_q  <= 1'b1;
                     end
                     8'h52: begin
                        pausa_q  <= 1'b0;
                        color_q  <= DEFAULT_COLOR;
                        speed_q  <= DEFAULT_SPEED;
                        cmd_ok_q <= 1'b1;
                     end
                     8'h0D, 8'h0A: ;
                     default: cmd_err_q <= 1'b1;
                  endcase
               end
               COL_HI: begin
                  if (hex_ok) begin
                     hi_q    <= hex_val;
                     state_q <= COL_LO;
                  end else begin
                     cmd_err_q <= 1'b1;
                     state_q   <= IDLE;
                     busy_q    <= 1'b0;
                  end
               end
               COL_LO: begin
                  if (hex_ok) begin
                     color_q  <= {hi_q, hex_val};
                     cmd_ok_q <= 1'b1;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  if (hex_ok) begin
                     speed_q  <= hex_val;
                     cmd_ok_q <= 1'b1;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
`ifdef BT_CMD_TIMEOUT_EN
         // A byte arriving on the expiry cycle takes the branch above instead.
         else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
               cmd_err_q <= 1'b1;
               state_q   <= IDLE;
               busy_q    <= 1'b0;
               cnt_q     <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
`endif
      end
   end

   assign pausa       = pausa_q;
   assign color       = color_q;
   assign speed       = speed_q;
   assign cmd_ok      = cmd_ok_q;
   assign cmd_err     = cmd_err_q;
   assign busy        = busy_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Self-checking bench for bt_cmd_ctrl: vector table plus hand-written
// timeout and mid-command reset sequences, scored through an expected queue.
module tb_bt_cmd_ctrl;

   localparam logic [7:0] DEF_C = 8'hFF;
   localparam logic [3:0] DEF_S = 4'd1;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       pausa;
   logic [7:0] color;
   logic [3:0] speed;
   logic       cmd_ok;
   logic       cmd_err;
   logic       busy;
   logic [1:0] state_dbg;

   bt_cmd_ctrl #(
      .TIMEOUT_CYCLES(16),
      .DEFAULT_COLOR (DEF_C),
      .DEFAULT_SPEED (DEF_S)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .pausa      (pausa),
      .color      (color),
      .speed      (speed),
      .cmd_ok     (cmd_ok),
      .cmd_err    (cmd_err),
      .busy       (busy),
      .state_dbg_o(state_dbg)
   );

   always #5 clk = ~clk;

   // {pausa, color, speed, cmd_ok, cmd_err, busy}
   localparam int W = 16;
   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       p;
      logic [7:0] c;
      logic [3:0] s;
      logic       ok;
      logic       err;
      logic       b;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [W-1:0] pk(input logic p, input logic [7:0] c,
                                       input logic [3:0] s, input logic ok,
                                       input logic err, input logic b);
      return {p, c, s, ok, err, b};
   endfunction

   function automatic void add(input logic v, input logic [7:0] d, input logic p,
                               input logic [7:0] c, input logic [3:0] s,
                               input logic ok, input logic err, input logic b);
      vec_t r;
      r.v = v; r.d = d; r.p = p; r.c = c; r.s = s; r.ok = ok; r.err = err; r.b = b;
      tbl.push_back(r);
   endfunction

   task automatic check(input string name);
      logic [W-1:0] act;
      logic [W-1:0] exp;
      exp = exp_q.pop_front();
      act = {pausa, color, speed, cmd_ok, cmd_err, busy};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got p=%b c=%h s=%h ok=%b err=%b busy=%b, want p=%b c=%h s=%h ok=%b err=%b busy=%b",
                  name, act[15], act[14:7], act[6:3], act[2], act[1], act[0],
                  exp[15], exp[14:7], exp[6:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Called at a negedge: drive, let one posedge sample it, check at next negedge.
   task automatic step(input logic v, input logic [7:0] d, input logic [W-1:0] exp,
                       input string name);
      rx_valid = v;
      rx_data  = v ? d : 8'($urandom_range(0, 255));
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      check(name);
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      exp_q.push_back(pk(1'b0, DEF_C, DEF_S, 1'b0, 1'b0, 1'b0));
      check("reset_state");
      reset = 1'b0;
      @(negedge clk);

      // v   data   p  color  spd ok err busy
      add(1, 8'h31, 1, 8'hFF, 1, 1, 0, 0);
      add(0, 8'h00, 1, 8'hFF, 1, 0, 0, 0);
      add(1, 8'h31, 0, 8'hFF, 1, 1, 0, 0);
      add(1, 8'h43, 0, 8'hFF, 1, 0, 0, 1);
      add(0, 8'h00, 0, 8'hFF, 1, 0, 0, 1);
      add(0, 8'h00, 0, 8'hFF, 1, 0, 0, 1);
      add(1, 8'h33, 0, 8'hFF, 1, 0, 0, 1);
      add(0, 8'h00, 0, 8'hFF, 1, 0, 0, 1);
      add(1, 8'h63, 0, 8'h3C, 1, 1, 0, 0);
      add(0, 8'h00, 0, 8'h3C, 1, 0, 0, 0);
      add(1, 8'h53, 0, 8'h3C, 1, 0, 0, 1);
      add(1, 8'h37, 0, 8'h3C, 7, 1, 0, 0);
      add(1, 8'h53, 0, 8'h3C, 7, 0, 0, 1);
      add(1, 8'h47, 0, 8'h3C, 7, 0, 1, 0);
      add(1, 8'h58, 0, 8'h3C, 7, 0, 1, 0);
      add(1, 8'h0D, 0, 8'h3C, 7, 0, 0, 0);
      add(1, 8'h0A, 0, 8'h3C, 7, 0, 0, 0);
      add(1, 8'h43, 0, 8'h3C, 7, 0, 0, 1);
      add(1, 8'h61, 0, 8'h3C, 7, 0, 0, 1);
      add(1, 8'h5A, 0, 8'h3C, 7, 0, 1, 0);
      add(1, 8'h43, 0, 8'h3C, 7, 0, 0, 1);
      add(1, 8'h40, 0, 8'h3C, 7, 0, 1, 0);
      add(1, 8'h43, 0, 8'h3C, 7, 0, 0, 1);
      add(1, 8'h46, 0, 8'h3C, 7, 0, 0, 1);
      add(1, 8'h30, 0, 8'hF0, 7, 1, 0, 0);
      add(1, 8'h53, 0, 8'hF0, 7, 0, 0, 1);
      add(1, 8'h2F, 0, 8'hF0, 7, 0, 1, 0);
      add(1, 8'h53, 0, 8'hF0, 7, 0, 0, 1);
      add(1, 8'h3A, 0, 8'hF0, 7, 0, 1, 0);
      add(1, 8'h53, 0, 8'hF0, 7, 0, 0, 1);
      add(1, 8'h60, 0, 8'hF0, 7, 0, 1, 0);
      add(1, 8'h53, 0, 8'hF0, 7, 0, 0, 1);
      add(1, 8'h66, 0, 8'hF0, 15, 1, 0, 0);
      add(1, 8'h53, 0, 8'hF0, 15, 0, 0, 1);
      add(1, 8'h39, 0, 8'hF0, 9, 1, 0, 0);
      add(1, 8'h43, 0, 8'hF0, 9, 0, 0, 1);
      add(1, 8'h39, 0, 8'hF0, 9, 0, 0, 1);
      add(1, 8'h41, 0, 8'h9A, 9, 1, 0, 0);
      add(1, 8'h31, 1, 8'h9A, 9, 1, 0, 0);
      add(1, 8'h52, 0, 8'hFF, 1, 1, 0, 0);
      add(1, 8'h67, 0, 8'hFF, 1, 0, 1, 0);
      add(1, 8'h31, 1, 8'hFF, 1, 1, 0, 0);
      add(1, 8'h31, 0, 8'hFF, 1, 1, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].v, tbl[i].d,
              pk(tbl[i].p, tbl[i].c, tbl[i].s, tbl[i].ok, tbl[i].err, tbl[i].b),
              $sformatf("vec%0d", i));
      end

`ifdef BT_CMD_TIMEOUT_EN
      // 'C','A' then silence: abort lands 16 cycles after 'A'.
      step(1, 8'h43, pk(0, 8'hFF, 1, 0, 0, 1), "to_c");
      step(1, 8'h41, pk(0, 8'hFF, 1, 0, 0, 1), "to_a");
      for (int k = 1; k < 16; k++)
         step(0, 8'h00, pk(0, 8'hFF, 1, 0, 0, 1), $sformatf("to_wait%0d", k));
      step(0, 8'h00, pk(0, 8'hFF, 1, 0, 1, 0), "to_expire");
      step(0, 8'h00, pk(0, 8'hFF, 1, 0, 0, 0), "to_after");
      // Byte arriving exactly on the expiry cycle wins.
      step(1, 8'h53, pk(0, 8'hFF, 1, 0, 0, 1), "race_s");
      for (int k = 1; k < 16; k++)
         step(0, 8'h00, pk(0, 8'hFF, 1, 0, 0, 1), $sformatf("race_wait%0d", k));
      step(1, 8'h35, pk(0, 8'hFF, 5, 1, 0, 0), "race_byte");
      step(1, 8'h52, pk(0, 8'hFF, 1, 1, 0, 0), "race_r");
`else
      // Without the timeout a partial command waits indefinitely.
      step(1, 8'h43, pk(0, 8'hFF, 1, 0, 0, 1), "nto_c");
      step(1, 8'h41, pk(0, 8'hFF, 1, 0, 0, 1), "nto_a");
      for (int k = 1; k <= 40; k++)
         step(0, 8'h00, pk(0, 8'hFF, 1, 0, 0, 1), $sformatf("nto_wait%0d", k));
      step(1, 8'h35, pk(0, 8'hA5, 1, 1, 0, 0), "nto_lo");
      step(1, 8'h52, pk(0, 8'hFF, 1, 1, 0, 0), "nto_r");
`endif

      // Reset in the middle of a colour command.
      step(1, 8'h43, pk(0, 8'hFF, 1, 0, 0, 1), "rst_c1");
      step(1, 8'h31, pk(0, 8'hFF, 1, 0, 0, 1), "rst_hi");
      step(1, 8'h32, pk(0, 8'h12, 1, 1, 0, 0), "rst_lo");
      step(1, 8'h31, pk(1, 8'h12, 1, 1, 0, 0), "rst_pause");
      step(1, 8'h43, pk(1, 8'h12, 1, 0, 0, 1), "rst_c2");
      step(1, 8'h34, pk(1, 8'h12, 1, 0, 0, 1), "rst_hi2");
      reset = 1'b1;
      #1;
      exp_q.push_back(pk(0, DEF_C, DEF_S, 0, 0, 0));
      check("rst_async");
      @(negedge clk);
      exp_q.push_back(pk(0, DEF_C, DEF_S, 0, 0, 0));
      check("rst_held");
      reset = 1'b0;
      for (int k = 0; k < 3; k++)
         step(0, 8'h00, pk(0, DEF_C, DEF_S, 0, 0, 0), $sformatf("rst_quiet%0d", k));
      step(1, 8'h35, pk(0, DEF_C, DEF_S, 0, 1, 0), "rst_idle_digit");

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL queue_drain: %0d left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Strobes must never overlap; checked continuously away from the edge.
   always @(negedge clk) begin
      if (!reset && cmd_ok && cmd_err) begin
         n_cmp++;
         n_bad++;
         $display("FAIL strobe_overlap: ok=%b err=%b, want not both", cmd_ok, cmd_err);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, want run complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bt_cmd_ctrl.md
# bt_cmd_ctrl

Command controller between the Bluetooth UART byte receiver and the VGA display logic. It consumes received bytes (byte plus one-cycle valid strobe) and parses a small ASCII command protocol. It maintains the display configuration registers (pause, colour, scroll speed) and emits per-command success/error strobes. It replaces the single-purpose "byte 0x31 toggles pause" behaviour with a sequenced, multi-byte command set that keeps '1' as a legacy command.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 5_000_000, idle clk cycles allowed between bytes of one command (100 ms at 50 MHz); minimum 2
- `DEFAULT_COLOR`, 8'hFF, colour value after reset or 'R' command
- `DEFAULT_SPEED`, 4'd1, speed value after reset or 'R' command

Ports:
- `clk` in 1: system clock, 50 MHz
- `reset` in 1: asynchronous, active-high
- `rx_data` in 8: received byte, valid only while `rx_valid` is high
- `rx_valid` in 1: one-cycle strobe, one byte per high cycle, synchronous to `clk`
- `pausa` out 1: display freeze, 1 = frozen
- `color` out 8: display colour, RRRGGGBB
- `speed` out 4: scroll speed
- `cmd_ok` out 1: one-cycle pulse, command completed and applied
- `cmd_err` out 1: one-cycle pulse, command aborted
- `busy` out 1: high while a multi-byte command is in progress (state ≠ IDLE)

## Operation
- The FSM has 4 states: IDLE, COL_HI, COL_LO, SPD.
- In IDLE, a byte on `rx_valid` is handled as follows:
  - 0x31 '1': toggle `pausa`, pulse `cmd_ok`, stay in IDLE.
  - 0x43 'C': go to COL_HI.
  - 0x53 'S': go to SPD.
  - 0x52 'R': `pausa`←0, `color`←DEFAULT_COLOR, `speed`←DEFAULT_SPEED, pulse `cmd_ok`.
  - 0x0D / 0x0A: ignored, no strobe.
  - Any other byte: pulse `cmd_err`, stay in IDLE.
- In COL_HI, a valid hex digit is latched as the high nibble into an internal holding register, then go to COL_LO. Any other byte: `cmd_err`, go to IDLE.
- In COL_LO, a valid hex digit sets `color` ← {hi, digit}, pulses `cmd_ok`, and goes to IDLE. Any other byte: `cmd_err`, IDLE, `color` unchanged.
- In SPD, a valid hex digit sets `speed` ← digit, pulses `cmd_ok`, and goes to IDLE. Any other byte: `cmd_err`, IDLE.
- Hex decode accepts '0'–'9' (0x30–0x39), 'A'–'F' (0x41–0x46) and 'a'–'f' (0x61–0x66). A decoded nibble is 4 bits.
- The timeout counter clears on every accepted byte and counts every clk cycle while not in IDLE.
  - If it reaches TIMEOUT_CYCLES−1 with no byte: pulse `cmd_err`, go to IDLE, leave config unchanged.
  - The counter is held at 0 in IDLE.
- A partially received command never modifies `color`, `speed` or `pausa`.

## Timing
- Reset values: state IDLE, `pausa`=0, `color`=DEFAULT_COLOR, `speed`=DEFAULT_SPEED, `cmd_ok`=0, `cmd_err`=0, `busy`=0, holding nibble 0, timeout counter 0.
- All outputs are registered.
- Latency: for the byte sampled at edge N with `rx_valid`=1, the config update, `cmd_ok`/`cmd_err` and the state change are all visible after edge N. Each strobe is high for exactly 1 cycle.
- `cmd_ok` and `cmd_err` are never high in the same cycle.
- Back-to-back `rx_valid` on consecutive cycles is supported: each byte is processed. A strobe may then be high for consecutive cycles, one per command.
- Simultaneous byte arrival and timeout expiry: the byte wins and the counter clears.
- Reset asserted mid-command: the next state is IDLE with defaults, and no strobe is emitted.

## Configuration
- `BT_CMD_TIMEOUT_EN` defined: the timeout counter and timeout abort are compiled in as described above.
- `BT_CMD_TIMEOUT_EN` undefined: there is no counter, and `TIMEOUT_CYCLES` is unused. A partial command waits indefinitely for its next byte; only a bad byte or reset aborts it.

## Test plan
- Reset, then byte 0x31 → `pausa` 0→1 and `cmd_ok` pulse. A second 0x31 → `pausa`=0 and a second `cmd_ok` pulse.
- Bytes 'C','3','c' with arbitrary gaps below the timeout → `busy` high after 'C', then `color`=8'h3C and one `cmd_ok` pulse after 'c'. `busy` low afterwards.
- Bytes 'S','7' on consecutive clk cycles → `speed`=4'h7, one `cmd_ok`. Then 'S','G' → `cmd_err` after 'G' and `speed` stays 7.
- With `BT_CMD_TIMEOUT_EN` and TIMEOUT_CYCLES=16: 'C','A', then silence → `cmd_err` exactly 16 cycles after 'A' is sampled, state IDLE, `color` unchanged.
- Byte 'X' (0x58) in IDLE → `cmd_err`. Bytes 0x0D and 0x0A → no strobe and no change.
- Set `color`=8'h12 and `pausa`=1, then send 'C','4', then assert `reset` before the low nibble → `color`=DEFAULT_COLOR, `pausa`=0, `busy`=0, no strobes.
